// File: rtl/rib_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin system-bus arbiter.
package rib_rr_arbiter_pkg;

  typedef enum logic {
    StIdle,
    StBusy
  } state_e;

  typedef enum logic [1:0] {
    M_JTAG    = 2'd0,
    M_UART    = 2'd1,
    M_CORE_EX = 2'd2,
    M_CORE_PC = 2'd3
  } master_e;

  localparam logic [31:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;

endpackage

// File: rtl/rib_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr_i, wrapping around.
module rib_rr_arbiter_rr_pick #(
  parameter int unsigned NUM_M = 4,
  parameter int unsigned PW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic             valid_o,
  output logic [PW-1:0]    grant_o
);

  int unsigned idx;

  always_comb begin
    valid_o = 1'b0;
    grant_o = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NUM_M) idx = idx - NUM_M;
      if (!valid_o && req_i[idx[PW-1:0]]) begin
        valid_o = 1'b1;
        grant_o = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/rib_rr_arbiter.sv
// Round-robin arbiter sharing one system-bus slave port between NUM_M masters,
// with wait-state support, a slave timeout and the core pipeline hold flag.
module rib_rr_arbiter
  import rib_rr_arbiter_pkg::*;
#(
  parameter int unsigned       NUM_M     = 4,
  parameter int unsigned       AW        = 32,
  parameter int unsigned       DW        = 32,
  parameter logic [NUM_M-1:0]  HOLD_MASK = NUM_M'(4'b1100),
  parameter int unsigned       TIMEOUT   = 255,
  parameter logic [DW-1:0]     ERR_DATA  = DW'(ERR_DATA_DFLT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    m_req_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_data_i,
  output logic [DW-1:0]       m_data_o,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic                m_err_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [AW-1:0]       s_addr_o,
  output logic [DW-1:0]       s_data_o,
  input  logic [DW-1:0]       s_data_i,
  input  logic                s_ack_i,
  output logic                hold_flag_o
);

  localparam int unsigned PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [NUM_M-1:0] ack_q, ack_d;
  logic             err_q, err_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic             pick_valid;
  logic [PW-1:0]    pick_grant;
  logic [NUM_M-1:0] eligible;

  // A master acked this cycle must not be re-granted on its stale request.
  assign eligible = m_req_i & ~ack_q;

  rib_rr_arbiter_rr_pick #(
    .NUM_M (NUM_M),
    .PW    (PW)
  ) u_rr_pick (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .grant_o (pick_grant)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tcnt_d   = tcnt_q;
    ack_d    = '0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          we_d    = m_we_i[pick_grant];
          addr_d  = m_addr_i[int'(pick_grant)*AW +: AW];
          wdata_d = m_data_i[int'(pick_grant)*DW +: DW];
          tcnt_d  = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        tcnt_d = tcnt_q + 1'b1;
        // A slave ack in the timeout cycle still counts as a good completion.
        if (s_ack_i || (tcnt_q == TW'(TIMEOUT - 1))) begin
          ack_d[grant_q] = 1'b1;
          err_d          = ~s_ack_i;
          rdata_d        = !s_ack_i ? ERR_DATA : (we_q ? '0 : s_data_i);
          rr_ptr_d       = (grant_q == PW'(NUM_M - 1)) ? '0 : grant_q + 1'b1;
          state_d        = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tcnt_q   <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tcnt_q   <= tcnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign s_req_o     = (state_q == StBusy);
  assign s_we_o      = s_req_o & we_q;
  assign s_addr_o    = s_req_o ? addr_q : '0;
  assign s_data_o    = s_req_o ? wdata_q : '0;
  assign m_ack_o     = ack_q;
  assign m_err_o     = err_q;
  assign m_data_o    = rdata_q;
  assign hold_flag_o = rst & (|(m_req_i & HOLD_MASK & ~ack_q));

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Self-checking bench for rib_rr_arbiter: vector table, scoreboard, corner sequences.
module tb_rib_rr_arbiter;

  localparam int unsigned NUM_M = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned TO    = 8;
  localparam logic [3:0]  HMASK = 4'b1100;

  logic                clk;
  logic                rst;
  logic [NUM_M-1:0]    m_req_i;
  logic [NUM_M-1:0]    m_we_i;
  logic [NUM_M*AW-1:0] m_addr_i;
  logic [NUM_M*DW-1:0] m_data_i;
  logic [DW-1:0]       m_data_o;
  logic [NUM_M-1:0]    m_ack_o;
  logic                m_err_o;
  logic                s_req_o;
  logic                s_we_o;
  logic [AW-1:0]       s_addr_o;
  logic [DW-1:0]       s_data_o;
  logic [DW-1:0]       s_data_i;
  logic                s_ack_i;
  logic                hold_flag_o;

  rib_rr_arbiter #(
    .NUM_M     (NUM_M),
    .AW        (AW),
    .DW        (DW),
    .HOLD_MASK (HMASK),
    .TIMEOUT   (TO),
    .ERR_DATA  (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (m_req_i),
    .m_we_i      (m_we_i),
    .m_addr_i    (m_addr_i),
    .m_data_i    (m_data_i),
    .m_data_o    (m_data_o),
    .m_ack_o     (m_ack_o),
    .m_err_o     (m_err_o),
    .s_req_o     (s_req_o),
    .s_we_o      (s_we_o),
    .s_addr_o    (s_addr_o),
    .s_data_o    (s_data_o),
    .s_data_i    (s_data_i),
    .s_ack_i     (s_ack_i),
    .hold_flag_o (hold_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrs   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [3:0]  ack;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  // ack_at = BUSY cycles before the slave acks; ack_at >= TO means no ack (timeout)
  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;
    logic [31:0] sdata;
  } vec_t;

  vec_t vecs[6];

  always @(negedge clk) begin
    if (rst && m_ack_o != '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'(m_ack_o), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_ack", 32'(m_ack_o), 32'(e.ack));
        check("sb_data", m_data_o, e.data);
        check("sb_err", 32'(m_err_o), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    logic timeout;
    timeout = (v.ack_at >= int'(TO));
    m_req_i[v.m]               = 1'b1;
    m_we_i[v.m]                = v.we;
    m_addr_i[v.m*AW +: AW]     = v.addr;
    m_data_i[v.m*DW +: DW]     = v.wdata;
    e.ack  = 4'b1 << v.m;
    e.err  = timeout;
    e.data = timeout ? 32'hDEAD_BEEF : (v.we ? 32'h0 : v.sdata);
    sb_q.push_back(e);
    #1;
    check("hold_c0", 32'(hold_flag_o), 32'(HMASK[v.m]));
    check("sreq_c0", 32'(s_req_o), 32'h0);
    tick();
    check("s_we", 32'(s_we_o), 32'(v.we));
    if (v.we) check("s_wdata", s_data_o, v.wdata);
    for (int w = 0; w < int'(TO); w++) begin
      check("s_req_busy", 32'(s_req_o), 32'h1);
      check("s_addr_busy", s_addr_o, v.addr);
      check("hold_busy", 32'(hold_flag_o), 32'(HMASK[v.m]));
      if (w == v.ack_at) begin
        s_ack_i  = 1'b1;
        s_data_i = v.sdata;
      end
      tick();
      s_ack_i = 1'b0;
      if (w == v.ack_at) break;
    end
    check("ack_time", 32'(m_ack_o), 32'(e.ack));
    check("hold_ackcyc", 32'(hold_flag_o), 32'h0);
    m_req_i[v.m] = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{m: 2, we: 1'b1, addr: 32'h1000_0004, wdata: 32'h0000_0055, ack_at: 0,
                sdata: 32'h0};
    vecs[1] = '{m: 3, we: 1'b0, addr: 32'h3000_0000, wdata: 32'h0, ack_at: TO,
                sdata: 32'h0};
    vecs[2] = '{m: 0, we: 1'b0, addr: 32'h0000_0100, wdata: 32'h0, ack_at: TO - 1,
                sdata: 32'hCAFE_F00D};
    vecs[3] = '{m: 2, we: 1'b0, addr: 32'h2000_0008, wdata: 32'h0, ack_at: 0,
                sdata: 32'hA5A5_0001};
    vecs[4] = '{m: 3, we: 1'b1, addr: 32'h4000_000C, wdata: 32'h0BAD_F00D, ack_at: 2,
                sdata: 32'hFFFF_FFFF};
    vecs[5] = '{m: 1, we: 1'b0, addr: 32'h2000_0010, wdata: 32'h0, ack_at: 5,
                sdata: 32'h1234_5678};

    rst      = 1'b0;
    m_req_i  = '0;
    m_we_i   = '0;
    m_addr_i = '0;
    m_data_i = '0;
    s_data_i = '0;
    s_ack_i  = 1'b0;
    tick();
    tick();
    check("rst_sreq", 32'(s_req_o), 32'h0);
    check("rst_ack", 32'(m_ack_o), 32'h0);
    check("rst_err", 32'(m_err_o), 32'h0);
    check("rst_data", m_data_o, 32'h0);
    check("rst_addr", s_addr_o, 32'h0);
    check("rst_hold", 32'(hold_flag_o), 32'h0);
    rst = 1'b1;
    tick();

    // s_ack_i in IDLE must be ignored
    s_ack_i = 1'b1;
    tick();
    s_ack_i = 1'b0;
    check("idle_ack_ignored", 32'(m_ack_o), 32'h0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Reset while BUSY: transfer dropped, no ack, hold gated by reset
    m_req_i[2]            = 1'b1;
    m_addr_i[2*AW +: AW]  = 32'h5555_0000;
    tick();
    check("pre_rst_busy", 32'(s_req_o), 32'h1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_sreq", 32'(s_req_o), 32'h0);
    check("async_rst_hold", 32'(hold_flag_o), 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_no_ack", 32'(m_ack_o), 32'h0);
    end
    m_req_i = '0;
    rst     = 1'b1;
    tick();

    // All masters requesting: grants 0,1,2,3,0,1, one transfer every 2 cycles
    for (int m = 0; m < 4; m++) m_addr_i[m*AW +: AW] = 32'h8000_0000 + 32'(m) * 32'h10;
    m_we_i  = '0;
    m_req_i = 4'hF;
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      int   exp_m;
      exp_m = k % 4;
      tick();
      check("rr_sreq", 32'(s_req_o), 32'h1);
      check("rr_addr", s_addr_o, 32'h8000_0000 + 32'(exp_m) * 32'h10);
      e.ack  = 4'b1 << exp_m;
      e.data = 32'hA000_0000 + 32'(k);
      e.err  = 1'b0;
      sb_q.push_back(e);
      s_ack_i  = 1'b1;
      s_data_i = 32'hA000_0000 + 32'(k);
      tick();
      s_ack_i = 1'b0;
      check("rr_ack", 32'(m_ack_o), 32'(e.ack));
    end
    m_req_i = '0;
    tick();
    tick();
    check("final_idle", 32'(s_req_o), 32'h0);
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule
